booth_datapath: RTL and testbench



---
 rtl/booth_datapath.sv | 128 ++++++++++++
 tb/tb_booth_datapath.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/booth_datapath.sv
// Radix-2 Booth multiplier datapath: holds M/A/Q/Qm1 and acts on Load/Operate/Shift strobes.
// Latency: one strobe action per clock; Product registers 1 clock after Ready is sampled rising.
// Backpressure: none; the control unit sequences strobes, and illegal sequences raise sticky ProtocolErr.
module booth_datapath #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       Load,
  input  logic                       Operate,
  input  logic                       Shift,
  input  logic                       Ready,
  input  logic [WIDTH-1:0]           Multiplicand,
  input  logic [WIDTH-1:0]           Multiplier,
  output logic [2*WIDTH-1:0]         Product,
  output logic                       ProductValid,
  output logic [$clog2(WIDTH+1)-1:0] ShiftCount,
  output logic                       ProtocolErr
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  // A and M carry one extra bit so that M = -2^(WIDTH-1) negates exactly.
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 pvalid_q, pvalid_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 ready_q, ready_d;

  logic [1:0]           n_strobes;
  logic                 ready_rise;
  logic                 cnt_full;

  assign n_strobes  = {1'b0, Load} + {1'b0, Operate} + {1'b0, Shift};
  assign ready_rise = Ready & ~ready_q;
  assign cnt_full   = (cnt_q == CNT_MAX);

  // Next-state: highest-priority strobe acts, then completion / Ready-edge checks.
  always_comb begin
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    product_d = product_q;
    pvalid_d  = pvalid_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ready_d   = Ready;

    if (n_strobes > 2'd1) begin
      err_d = 1'b1;
    end

    if (Load) begin
      m_d      = {Multiplicand[WIDTH-1], Multiplicand};
      q_d      = Multiplier;
      a_d      = '0;
      qm1_d    = 1'b0;
      cnt_d    = '0;
      pvalid_d = 1'b0;
    end else if (Operate) begin
      if (!cnt_full) begin
        case ({q_q[0], qm1_q})
          2'b01:   a_d = a_q + m_q;
          2'b10:   a_d = a_q - m_q;
          default: a_d = a_q;
        endcase
      end else begin
        err_d = 1'b1;
      end
    end else if (Shift) begin
      if (!cnt_full) begin
        {a_d, q_d, qm1_d} = {a_q[WIDTH], a_q, q_q};
        cnt_d             = cnt_q + CW'(1);
      end else begin
        err_d = 1'b1;
      end
    end

    // A Load in the same cycle wins over completion so the fresh operands start clean.
    if (ready_rise) begin
      if (cnt_full) begin
        if (!Load) begin
          product_d = {a_q[WIDTH-1:0], q_q};
          pvalid_d  = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-high reset overriding all strobes.
  always_ff @(posedge clk) begin
    if (Reset) begin
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      product_q <= '0;
      pvalid_q  <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      product_q <= product_d;
      pvalid_q  <= pvalid_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  assign Product      = product_q;
  assign ProductValid = pvalid_q;
  assign ShiftCount   = cnt_q;
  assign ProtocolErr  = err_q;

endmodule

// File: tb/tb_booth_datapath.sv
// Directed bench for booth_datapath with hand-computed expected products and flags.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Every comparison goes through chk, which counts and reports mismatches.
module tb_booth_datapath;

  localparam int W = 8;

  logic           clk;
  logic           Reset;
  logic           Load;
  logic           Operate;
  logic           Shift;
  logic           Ready;
  logic [W-1:0]   Multiplicand;
  logic [W-1:0]   Multiplier;
  logic [2*W-1:0] Product;
  logic           ProductValid;
  logic [3:0]     ShiftCount;
  logic           ProtocolErr;

  int total = 0;
  int bad   = 0;

  booth_datapath #(.WIDTH(W)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .Load         (Load),
    .Operate      (Operate),
    .Shift        (Shift),
    .Ready        (Ready),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Product      (Product),
    .ProductValid (ProductValid),
    .ShiftCount   (ShiftCount),
    .ProtocolErr  (ProtocolErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] m, input logic [W-1:0] q);
    Multiplicand = m;
    Multiplier   = q;
    Load         = 1'b1;
    tick();
    Load         = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      Operate = 1'b1;
      tick();
      Operate = 1'b0;
      Shift   = 1'b1;
      tick();
      Shift   = 1'b0;
    end
  endtask

  task automatic ready_pulse();
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
  endtask

  task automatic finish_mult();
    steps(W);
    ready_pulse();
  endtask

  initial begin
    Reset = 1'b0; Load = 1'b0; Operate = 1'b0; Shift = 1'b0; Ready = 1'b0;
    Multiplicand = '0; Multiplier = '0;

    // Reset state
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    chk("rst_product", 32'(Product), 32'h0);
    chk("rst_valid", 32'(ProductValid), 32'h0);
    chk("rst_count", 32'(ShiftCount), 32'h0);
    chk("rst_err", 32'(ProtocolErr), 32'h0);

    // 3 x -4 = -12
    do_load(8'd3, 8'hFC);
    chk("load_valid", 32'(ProductValid), 32'h0);
    chk("load_count", 32'(ShiftCount), 32'h0);
    finish_mult();
    chk("m3x-4_product", 32'(Product), 32'hFFF4);
    chk("m3x-4_valid", 32'(ProductValid), 32'h1);
    chk("m3x-4_count", 32'(ShiftCount), 32'h8);
    chk("m3x-4_err", 32'(ProtocolErr), 32'h0);

    // Extra shift after completion: saturate, flag, datapath untouched
    Shift = 1'b1;
    tick();
    Shift = 1'b0;
    chk("xshift_count", 32'(ShiftCount), 32'h8);
    chk("xshift_err", 32'(ProtocolErr), 32'h1);
    ready_pulse();
    chk("xshift_recapture", 32'(Product), 32'hFFF4);
    chk("xshift_valid", 32'(ProductValid), 32'h1);

    // Load clears valid, keeps sticky error and old product
    do_load(8'h80, 8'h80);
    chk("reload_valid", 32'(ProductValid), 32'h0);
    chk("reload_err", 32'(ProtocolErr), 32'h1);
    chk("reload_product", 32'(Product), 32'hFFF4);
    finish_mult();
    chk("m-128x-128", 32'(Product), 32'h4000);

    do_load(8'd127, 8'd127);
    finish_mult();
    chk("m127x127", 32'(Product), 32'h3F01);

    do_load(8'd0, 8'hFF);
    finish_mult();
    chk("m0x-1", 32'(Product), 32'h0000);
    chk("m0x-1_valid", 32'(ProductValid), 32'h1);

    // Load together with Shift: load wins, no shift, error flagged
    do_reset();
    Multiplicand = 8'd7;
    Multiplier   = 8'd9;
    Load  = 1'b1;
    Shift = 1'b1;
    tick();
    Load  = 1'b0;
    Shift = 1'b0;
    chk("ldsh_count", 32'(ShiftCount), 32'h0);
    chk("ldsh_err", 32'(ProtocolErr), 32'h1);
    finish_mult();
    chk("ldsh_product", 32'(Product), 32'h003F);

    // Reset mid-multiply alongside Operate
    do_reset();
    do_load(8'd2, 8'd3);
    steps(4);
    chk("mid_count", 32'(ShiftCount), 32'h4);
    Reset   = 1'b1;
    Operate = 1'b1;
    tick();
    Reset   = 1'b0;
    Operate = 1'b0;
    chk("midrst_product", 32'(Product), 32'h0);
    chk("midrst_valid", 32'(ProductValid), 32'h0);
    chk("midrst_count", 32'(ShiftCount), 32'h0);
    chk("midrst_err", 32'(ProtocolErr), 32'h0);
    do_load(8'd5, 8'd6);
    finish_mult();
    chk("m5x6", 32'(Product), 32'h001E);
    chk("m5x6_err", 32'(ProtocolErr), 32'h0);

    // Premature Ready after 5 shifts
    do_load(8'd3, 8'd5);
    steps(5);
    ready_pulse();
    chk("early_valid", 32'(ProductValid), 32'h0);
    chk("early_product", 32'(Product), 32'h001E);
    chk("early_err", 32'(ProtocolErr), 32'h1);
    chk("early_count", 32'(ShiftCount), 32'h5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
